// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler for the five-stage LA32 core.
// Watches stage occupancy, register numbers and the multi-cycle / data-memory
// handshakes, and produces per-stage stall and bubble controls so that the
// forwarding network only sees operands resolvable by MEM/WB bypass.
// Stall/flush outputs are Mealy: decoded from the current state and inputs.
module hazard_sched #(
  parameter int CNT_W     = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             id_valid,
  input  logic [4:0]       id_rj_no,
  input  logic [4:0]       id_rk_no,
  input  logic [4:0]       id_rd_no,
  input  logic             id_use_rj,
  input  logic             id_use_rk,
  input  logic             id_use_rd,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_no,
  input  logic             ex_reg_we,
  input  logic             ex_multicycle,
  input  logic             ex_finish,
  input  logic             br_taken_ex,
  input  logic             mem_req_valid,
  input  logic             mem_data_ok,
  input  logic             excp_wb,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [1:0]       FLUSH_LD = 2'(FLUSH_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       lu;
  logic       run_rules;

  assign state_o = state_q;

  // Load-use hazard: a load in EX whose destination is read by the ID instruction.
  // ex_rd_no != 0 already guarantees a matching source is never r0.
  always_comb begin
    lu = ex_valid && ex_is_load && ex_reg_we && (ex_rd_no != 5'd0) && id_valid &&
         ((id_use_rj && (id_rj_no == ex_rd_no)) ||
          (id_use_rk && (id_rk_no == ex_rd_no)) ||
          (id_use_rd && (id_rd_no == ex_rd_no)));
  end

  // Next-state and output decode. A completing wait state falls through to the
  // RUN rules so a same-cycle branch, load-use or new stall is not lost.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    run_rules = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;

    if (excp_wb) begin
      // Exception/ertn redirect wins over everything and (re)starts FLUSH.
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
      flush_wb  = 1'b1;
      state_d   = FLUSH;
      fcnt_d    = FLUSH_LD;
    end else begin
      unique case (state_q)
        FLUSH: begin
          stall_if = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          if (fcnt_q <= 2'd1) begin
            state_d = RUN;
            fcnt_d  = 2'd0;
          end else begin
            fcnt_d  = fcnt_q - 2'd1;
          end
        end
        EX_WAIT: begin
          if (!ex_finish) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            flush_mem = 1'b1;
          end else begin
            run_rules = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_data_ok) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
          end else begin
            run_rules = 1'b1;
          end
        end
        default: run_rules = 1'b1;
      endcase

      if (run_rules) begin
        state_d = RUN;
        if (mem_req_valid && !mem_data_ok) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          flush_wb  = 1'b1;
          state_d   = MEM_WAIT;
        end else if (ex_valid && ex_multicycle && !ex_finish) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          flush_mem = 1'b1;
          state_d   = EX_WAIT;
        end else if (ex_valid && br_taken_ex) begin
          // Taken branch squashes the wrong-path instructions in IF/ID and ID/EX;
          // any load-use in ID is moot because that instruction is discarded.
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (lu) begin
          // Hold IF/ID one cycle and inject one bubble into EX.
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end
  end

  // State and flush-counter registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt <= '0;
    end else if (stall_if && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed and randomized bench for hazard_sched with a cycle-level reference model.
module tb_hazard_sched;

  localparam int CNT_W     = 3;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       id_valid;
  logic [4:0] id_rj_no, id_rk_no, id_rd_no;
  logic       id_use_rj, id_use_rk, id_use_rd;
  logic       ex_valid, ex_is_load;
  logic [4:0] ex_rd_no;
  logic       ex_reg_we, ex_multicycle, ex_finish, br_taken_ex;
  logic       mem_req_valid, mem_data_ok, excp_wb;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, flush_mem, flush_wb;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [7:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 run, 1 waiting on EX unit, 2 waiting on memory, 3 flushing.
  int         m_mode, m_left, m_cnt;
  logic [7:0] e_out;
  int         e_mode, e_left;

  always #5 aclk = ~aclk;

  hazard_sched #(.CNT_W(CNT_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .id_valid(id_valid), .id_rj_no(id_rj_no), .id_rk_no(id_rk_no), .id_rd_no(id_rd_no),
    .id_use_rj(id_use_rj), .id_use_rk(id_use_rk), .id_use_rd(id_use_rd),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_no(ex_rd_no),
    .ex_reg_we(ex_reg_we), .ex_multicycle(ex_multicycle), .ex_finish(ex_finish),
    .br_taken_ex(br_taken_ex), .mem_req_valid(mem_req_valid), .mem_data_ok(mem_data_ok),
    .excp_wb(excp_wb),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .state_o(state_o), .stall_cnt(stall_cnt)
  );

  assign obs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic src_hit(input logic use_src, input logic [4:0] no);
    return use_src && (no != 5'd0) && (no == ex_rd_no);
  endfunction

  // Expected outputs {stall_if,id,ex,mem, flush_id,ex,mem,wb} and next mode.
  task automatic model_eval();
    logic lu_m;
    lu_m = ex_valid && ex_is_load && ex_reg_we && (ex_rd_no != 5'd0) && id_valid &&
           (src_hit(id_use_rj, id_rj_no) || src_hit(id_use_rk, id_rk_no) ||
            src_hit(id_use_rd, id_rd_no));
    e_mode = m_mode;
    e_left = m_left;
    if (excp_wb) begin
      e_out = 8'b0000_1111; e_mode = 3; e_left = FLUSH_CYC;
    end else if (m_mode == 3) begin
      e_out = 8'b1000_1100; e_left = m_left - 1; e_mode = (e_left > 0) ? 3 : 0;
    end else if (m_mode == 1 && !ex_finish) begin
      e_out = 8'b1110_0010;
    end else if (m_mode == 2 && !mem_data_ok) begin
      e_out = 8'b1111_0001;
    end else if (mem_req_valid && !mem_data_ok) begin
      e_out = 8'b1111_0001; e_mode = 2;
    end else if (ex_valid && ex_multicycle && !ex_finish) begin
      e_out = 8'b1110_0010; e_mode = 1;
    end else if (ex_valid && br_taken_ex) begin
      e_out = 8'b0000_1100; e_mode = 0;
    end else if (lu_m) begin
      e_out = 8'b1100_0100; e_mode = 0;
    end else begin
      e_out = 8'b0000_0000; e_mode = 0;
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rj_no = 0; id_rk_no = 0; id_rd_no = 0;
    id_use_rj = 0; id_use_rk = 0; id_use_rd = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd_no = 0; ex_reg_we = 0;
    ex_multicycle = 0; ex_finish = 0; br_taken_ex = 0;
    mem_req_valid = 0; mem_data_ok = 0; excp_wb = 0;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one clock.
  task automatic cycle(input string tag);
    #1;
    model_eval();
    check({tag, "_outs"}, 32'(obs), 32'(e_out));
    check({tag, "_state"}, 32'(state_o), 32'(m_mode));
    check({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    @(posedge aclk);
    if (e_out[7] && m_cnt < CNT_SAT) m_cnt++;
    m_mode = e_mode;
    m_left = e_left;
    @(negedge aclk);
  endtask

  // Asynchronous reset applied mid-cycle; state and counter must drop at once.
  task automatic do_reset(input string tag);
    aresetn = 0;
    m_mode = 0; m_left = 0; m_cnt = 0;
    #1;
    model_eval();
    check({tag, "_rst_state"}, 32'(state_o), 32'd0);
    check({tag, "_rst_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, "_rst_outs"}, 32'(obs), 32'(e_out));
    idle();
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1;
  endtask

  initial begin
    idle();
    aresetn = 1;
    @(negedge aclk);
    do_reset("init");
    check("init_outs_idle", 32'(obs), 32'd0);

    // Load-use through rk on r5: one stall cycle with a bubble, then clear.
    ex_valid = 1; ex_is_load = 1; ex_reg_we = 1; ex_rd_no = 5'd5;
    id_valid = 1; id_use_rk = 1; id_rk_no = 5'd5;
    #1 check("lu_r5_outs", 32'(obs), 32'b1100_0100);
    cycle("lu_r5");
    ex_valid = 0; ex_is_load = 0; ex_reg_we = 0;
    cycle("lu_r5_after");
    check("lu_r5_cnt", 32'(stall_cnt), 32'd1);
    // Same with r0: never a hazard.
    ex_valid = 1; ex_is_load = 1; ex_reg_we = 1; ex_rd_no = 5'd0; id_rk_no = 5'd0;
    #1 check("lu_r0_outs", 32'(obs), 32'd0);
    cycle("lu_r0");
    idle();

    // Divide finishing 4 cycles after entering EX.
    do_reset("div");
    ex_valid = 1; ex_multicycle = 1;
    for (int i = 0; i < 4; i++) begin
      cycle("div_wait");
      check("div_state_wait", 32'(state_o), 32'd1);
    end
    ex_finish = 1;
    cycle("div_fin");
    check("div_state_run", 32'(state_o), 32'd0);
    check("div_cnt", 32'(stall_cnt), 32'd4);
    idle();

    // Memory wait of 3 cycles, then a response in the request cycle.
    do_reset("mem");
    mem_req_valid = 1;
    cycle("mem_req");
    mem_req_valid = 0;
    cycle("mem_w1");
    cycle("mem_w2");
    mem_data_ok = 1;
    #1 check("mem_ok_outs", 32'(obs), 32'd0);
    cycle("mem_ok");
    check("mem_cnt", 32'(stall_cnt), 32'd3);
    mem_req_valid = 1;
    #1 check("mem_fast_outs", 32'(obs), 32'd0);
    cycle("mem_fast");
    check("mem_fast_state", 32'(state_o), 32'd0);
    idle();

    // Taken branch wins over a simultaneous load-use.
    ex_valid = 1; ex_is_load = 1; ex_reg_we = 1; ex_rd_no = 5'd7;
    id_valid = 1; id_use_rj = 1; id_rj_no = 5'd7; br_taken_ex = 1;
    #1 check("br_lu_outs", 32'(obs), 32'b0000_1100);
    cycle("br_lu");
    idle();

    // Exception during EX_WAIT, coinciding with ex_finish.
    ex_valid = 1; ex_multicycle = 1;
    cycle("exc_enter");
    cycle("exc_wait");
    ex_finish = 1; excp_wb = 1;
    #1 check("exc_outs", 32'(obs), 32'b0000_1111);
    cycle("exc");
    idle();
    check("exc_state_flush", 32'(state_o), 32'd3);
    cycle("exc_f1");
    check("exc_state_f1", 32'(state_o), 32'd3);
    cycle("exc_f2");
    check("exc_state_run", 32'(state_o), 32'd0);
    // Exception inside FLUSH reloads the counter.
    excp_wb = 1; cycle("rel_exc1"); excp_wb = 0;
    cycle("rel_f1");
    excp_wb = 1; cycle("rel_exc2"); excp_wb = 0;
    cycle("rel_f1b");
    check("rel_still_flush", 32'(state_o), 32'd3);
    cycle("rel_f2b");
    check("rel_run", 32'(state_o), 32'd0);

    // Asynchronous reset in the middle of a memory wait.
    mem_req_valid = 1;
    cycle("rstm_req");
    mem_req_valid = 0;
    cycle("rstm_wait");
    check("rstm_state_wait", 32'(state_o), 32'd2);
    do_reset("rstm");

    // Counter saturation: 10 stall cycles into a 3-bit counter.
    mem_req_valid = 1;
    cycle("sat_req");
    mem_req_valid = 0;
    for (int i = 0; i < 9; i++) cycle("sat_wait");
    check("sat_cnt", 32'(stall_cnt), 32'(CNT_SAT));
    mem_data_ok = 1;
    cycle("sat_done");
    idle();

    // Randomized traffic against the model.
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      id_valid      = 1'($urandom_range(0, 1));
      id_rj_no      = 5'($urandom_range(0, 3));
      id_rk_no      = 5'($urandom_range(0, 3));
      id_rd_no      = 5'($urandom_range(0, 3));
      id_use_rj     = 1'($urandom_range(0, 1));
      id_use_rk     = 1'($urandom_range(0, 1));
      id_use_rd     = 1'($urandom_range(0, 1));
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_is_load    = 1'($urandom_range(0, 1));
      ex_rd_no      = 5'($urandom_range(0, 3));
      ex_reg_we     = ($urandom_range(0, 3) != 0);
      ex_multicycle = ($urandom_range(0, 5) == 0);
      ex_finish     = ($urandom_range(0, 2) == 0);
      br_taken_ex   = ($urandom_range(0, 5) == 0);
      mem_req_valid = ($urandom_range(0, 4) == 0);
      mem_data_ok   = 1'($urandom_range(0, 1));
      excp_wb       = ($urandom_range(0, 19) == 0);
      cycle("rnd");
      if (i == 300) do_reset("rnd_mid");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
